// File: rtl/sm_fifo_pkg.sv
// Shared constants, depth helper and push/pop operation encoding for sm_fifo.
package sm_fifo_pkg;

  localparam int unsigned SM_FIFO_WIDTH_DEF = 32;

  function automatic int unsigned sm_fifo_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

  // Bit order matches {pop, push} so the accepted-op pair casts directly.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } sm_fifo_op_e;

endpackage

// File: rtl/sm_fifo_if.sv
// Producer/consumer side of sm_fifo: push/pop requests, registered data and status.
interface sm_fifo_if
  import sm_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = SM_FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2 = 2
);
  logic                  we;
  logic [WIDTH-1:0]      d;
  logic                  re;
  logic [WIDTH-1:0]      q;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output we, d, re,
    input  q, empty, full, count, overflow, underflow
  );

  modport slave (
    input  we, d, re,
    output q, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/sm_fifo_ptr.sv
// DEPTH_LOG2-bit FIFO pointer: increments on inc_i, wraps naturally mod 2**DEPTH_LOG2.
module sm_fifo_ptr
  import sm_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_i,
  output logic [DEPTH_LOG2-1:0] ptr_o
);
  logic [DEPTH_LOG2-1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_q + DEPTH_LOG2'(1);
    end
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/sm_fifo.sv
// Synchronous FIFO with registered pop data; rst is asynchronous active-low.
// Build option SM_FIFO_STATUS_EN adds sticky overflow/underflow flops.
module sm_fifo
  import sm_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = SM_FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  sm_fifo_if.slave   bus
);
  localparam int unsigned         DEPTH     = sm_fifo_depth(DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      q_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  empty, full, push, pop;
  sm_fifo_op_e           op;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);
  assign push  = bus.we & (~full | bus.re);
  assign pop   = bus.re & ~empty;
  assign op    = sm_fifo_op_e'({pop, push});

  sm_fifo_ptr #(.DEPTH_LOG2(DEPTH_LOG2)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  sm_fifo_ptr #(.DEPTH_LOG2(DEPTH_LOG2)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

  // When full, wr_ptr == rd_ptr; the read sees the old word before the write lands.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= bus.d;
    end
  end

  always_comb begin
    count_d = count_q;
    case (op)
      OP_PUSH: count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      OP_POP:  count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      q_q     <= '0;
    end else begin
      count_q <= count_d;
      if (pop) begin
        q_q <= mem_q[rd_ptr];
      end
    end
  end

  assign bus.q     = q_q;
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.count = count_q;

`ifdef SM_FIFO_STATUS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.we & ~push) ovf_q <= 1'b1;
      if (bus.re & ~pop)  udf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sm_fifo.sv
// Bench for sm_fifo: DEPTH_LOG2=2 and DEPTH_LOG2=1 instances share stimulus, checked against queue models.
module tb_sm_fifo;
`ifdef SM_FIFO_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tb_we = 1'b0;
  logic        tb_re = 1'b0;
  logic [31:0] tb_d = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] exp_q   [2];
  bit          exp_ovf [2];
  bit          exp_udf [2];

  always #5 clk = ~clk;

  sm_fifo_if #(.WIDTH(32), .DEPTH_LOG2(2)) bus0 ();
  sm_fifo_if #(.WIDTH(32), .DEPTH_LOG2(1)) bus1 ();

  assign bus0.we = tb_we;
  assign bus0.d  = tb_d;
  assign bus0.re = tb_re;
  assign bus1.we = tb_we;
  assign bus1.d  = tb_d;
  assign bus1.re = tb_re;

  sm_fifo #(.WIDTH(32), .DEPTH_LOG2(2)) dut0 (.clk(clk), .rst(rst_n), .bus(bus0));
  sm_fifo #(.WIDTH(32), .DEPTH_LOG2(1)) dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      exp_q[k]   = '0;
      exp_ovf[k] = 1'b0;
      exp_udf[k] = 1'b0;
    end
  endtask

  // One clock edge of an ideal FIFO of depth dep holding sz words.
  task automatic model_step(input int k);
    int unsigned sz, dep;
    bit push_ok, pop_ok;
    sz  = (k == 0) ? mq0.size() : mq1.size();
    dep = (k == 0) ? 4 : 2;
    push_ok = tb_we && ((sz != dep) || tb_re);
    pop_ok  = tb_re && (sz != 0);
    if (pop_ok) begin
      if (k == 0) exp_q[k] = mq0.pop_front();
      else        exp_q[k] = mq1.pop_front();
    end
    if (push_ok) begin
      if (k == 0) mq0.push_back(tb_d);
      else        mq1.push_back(tb_d);
    end
    if (STATUS && tb_we && !push_ok) exp_ovf[k] = 1'b1;
    if (STATUS && tb_re && !pop_ok)  exp_udf[k] = 1'b1;
  endtask

  task automatic check_all(input string tag);
    int unsigned s0, s1;
    s0 = mq0.size();
    s1 = mq1.size();
    check({tag, ".q0"},   bus0.q, exp_q[0]);
    check({tag, ".cnt0"}, 32'(bus0.count), s0);
    check({tag, ".emp0"}, 32'(bus0.empty), 32'(s0 == 0));
    check({tag, ".ful0"}, 32'(bus0.full),  32'(s0 == 4));
    check({tag, ".ovf0"}, 32'(bus0.overflow),  32'(exp_ovf[0]));
    check({tag, ".udf0"}, 32'(bus0.underflow), 32'(exp_udf[0]));
    check({tag, ".q1"},   bus1.q, exp_q[1]);
    check({tag, ".cnt1"}, 32'(bus1.count), s1);
    check({tag, ".emp1"}, 32'(bus1.empty), 32'(s1 == 0));
    check({tag, ".ful1"}, 32'(bus1.full),  32'(s1 == 2));
    check({tag, ".ovf1"}, 32'(bus1.overflow),  32'(exp_ovf[1]));
    check({tag, ".udf1"}, 32'(bus1.underflow), 32'(exp_udf[1]));
  endtask

  task automatic cycle(input string tag, input bit we, input logic [31:0] d, input bit re);
    tb_we = we;
    tb_d  = d;
    tb_re = re;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    tb_we = 1'b0;
    tb_re = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all({tag, ".in"});
    @(posedge clk);
    #1;
    check_all({tag, ".hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    #2;
    check_all("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-stream with 3 words queued, then a pop after release is ignored
    cycle("t1.push", 1'b1, 32'h0000_0001, 1'b0);
    cycle("t1.push", 1'b1, 32'h0000_0002, 1'b0);
    cycle("t1.push", 1'b1, 32'h0000_0003, 1'b0);
    check("t1.cnt3", 32'(bus0.count), 32'd3);
    do_reset("t1.rst");
    cycle("t1.pop_empty", 1'b0, 32'h0, 1'b1);
    check("t1.q_zero", bus0.q, 32'h0);

    // Order and latency
    do_reset("t2.rst");
    cycle("t2.push", 1'b1, 32'h11, 1'b0);
    cycle("t2.push", 1'b1, 32'h22, 1'b0);
    cycle("t2.push", 1'b1, 32'h33, 1'b0);
    cycle("t2.push", 1'b1, 32'h44, 1'b0);
    check("t2.full0", 32'(bus0.full), 32'd1);
    check("t2.cnt4",  32'(bus0.count), 32'd4);
    check("t6.full1", 32'(bus1.full), 32'd1);
    cycle("t2.pop", 1'b0, 32'h0, 1'b1);
    check("t2.q11", bus0.q, 32'h11);
    cycle("t2.pop", 1'b0, 32'h0, 1'b1);
    check("t2.q22", bus0.q, 32'h22);
    cycle("t2.pop", 1'b0, 32'h0, 1'b1);
    check("t2.q33", bus0.q, 32'h33);
    cycle("t2.pop", 1'b0, 32'h0, 1'b1);
    check("t2.q44", bus0.q, 32'h44);
    check("t2.empty", 32'(bus0.empty), 32'd1);

    // Full boundary: drop while full, then push+pop while full
    do_reset("t3.rst");
    for (int i = 1; i <= 4; i++) cycle("t3.fill", 1'b1, 32'(i * 'h11), 1'b0);
    cycle("t3.drop", 1'b1, 32'h55, 1'b0);
    check("t3.cnt4", 32'(bus0.count), 32'd4);
    check("t3.ovf",  32'(bus0.overflow), 32'(STATUS));
    cycle("t3.both", 1'b1, 32'h66, 1'b1);
    check("t3.q11",  bus0.q, 32'h11);
    check("t3.cnt",  32'(bus0.count), 32'd4);
    check("t6.fullkeep", 32'(bus1.full), 32'd1);
    for (int i = 0; i < 4; i++) cycle("t3.drain", 1'b0, 32'h0, 1'b1);
    check("t3.last66", bus0.q, 32'h66);

    // Empty boundary: pop ignored, same-cycle push accepted
    cycle("t4.both_empty", 1'b1, 32'hAA, 1'b1);
    check("t4.qhold", bus0.q, 32'h66);
    check("t4.cnt1",  32'(bus0.count), 32'd1);
    check("t4.udf",   32'(bus0.underflow), 32'(STATUS));
    cycle("t4.pop", 1'b0, 32'h0, 1'b1);
    check("t4.qAA", bus0.q, 32'hAA);

    // Wrap at count=2 steady state
    do_reset("t5.rst");
    cycle("t5.pre", 1'b1, 32'h100, 1'b0);
    cycle("t5.pre", 1'b1, 32'h101, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle("t5.pair", 1'b1, 32'(32'h102 + i), 1'b1);
      check("t5.seq", bus0.q, 32'(32'h100 + i));
      check("t5.cnt2", 32'(bus0.count), 32'd2);
    end

    // Random traffic with one mid-run reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rnd.rst");
      cycle("rnd", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
